// File: rtl/pipe_delay_line.sv
// pipe_delay_line: DEPTH-stage registered delay line for WIDTH-bit data plus
// a valid qualifier. Every stage takes its predecessor's pre-edge value, so a
// sample captured on an enabled edge reaches the last stage after exactly
// DEPTH enabled edges. Stalls (en=0) freeze every stage; flush clears them.
//
// Ports:
//   clk        : single clock, all state updates on posedge
//   rst        : synchronous reset, active-high (highest priority)
//   en         : advance enable; 0 holds every stage and the occupancy count
//   flush      : synchronous clear of all stages (below rst, above en)
//   din_valid  : valid qualifier for din
//   din        : input data
//   tap_sel    : stage index driven onto the tap outputs (0 = first stage)
//   dout       : data of stage DEPTH-1 (registered)
//   dout_valid : valid of stage DEPTH-1 (registered)
//   tap_dout   : data of stage tap_sel (combinational mux of registers)
//   tap_valid  : valid of stage tap_sel (combinational mux of registers)
//   occupancy  : number of stages currently holding valid=1 (registered)

module pipe_delay_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SEL_W = 2,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    input  logic [SEL_W-1:0] tap_sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [WIDTH-1:0] tap_dout,
    output logic             tap_valid,
    output logic [CNT_W-1:0] occupancy
);

    // Configuration checks: the tap index must reach every stage and the
    // occupancy counter must be able to represent a completely full pipe.
    if (WIDTH < 1) begin : g_bad_width
        $error("pipe_delay_line: WIDTH must be >= 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("pipe_delay_line: DEPTH must be >= 1");
    end
    if ((2 ** SEL_W) < DEPTH) begin : g_bad_sel_w
        $error("pipe_delay_line: SEL_W too small, need 2**SEL_W >= DEPTH");
    end
    if ((2 ** CNT_W) <= DEPTH) begin : g_bad_cnt_w
        $error("pipe_delay_line: CNT_W too small, need 2**CNT_W > DEPTH");
    end

    // Stage storage and next-state.
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;

    // Next-state: flush clears, en shifts (bubbles carry their data), else hold.
    always_comb begin
        data_d = data_q;
        v_d    = v_q;
        occ_d  = occ_q;
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_d[i] = '0;
            end
            v_d   = '0;
            occ_d = '0;
        end else if (en) begin
            data_d[0] = din;
            v_d[0]    = din_valid;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                data_d[i] = data_q[i-1];
                v_d[i]    = v_q[i-1];
            end
            // One valid may enter and one may leave on the same edge.
            occ_d = occ_q + CNT_W'(din_valid) - CNT_W'(v_q[DEPTH-1]);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            v_q   <= '0;
            occ_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            v_q   <= v_d;
            occ_q <= occ_d;
        end
    end

    // Last stage and counter drive the outputs straight from registers.
    assign dout       = data_q[DEPTH-1];
    assign dout_valid = v_q[DEPTH-1];
    assign occupancy  = occ_q;

    // Tap mux; indices beyond the last stage read as an empty stage.
    always_comb begin
        tap_dout  = '0;
        tap_valid = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (tap_sel == SEL_W'(i)) begin
                tap_dout  = data_q[i];
                tap_valid = v_q[i];
            end
        end
    end

endmodule

// File: tb/tb_pipe_delay_line.sv
// Directed bench for pipe_delay_line: DEPTH=4 main instance, plus DEPTH=3
// (out-of-range tap) and DEPTH=1 (single stage) instances on shared inputs.

module tb_pipe_delay_line;

    logic       clk;
    logic       rst;
    logic       en;
    logic       flush;
    logic       din_valid;
    logic [7:0] din;
    logic [1:0] tap_sel;

    logic [7:0] d4_dout, d4_tap;
    logic       d4_dv, d4_tv;
    logic [2:0] d4_occ;

    logic [7:0] d3_dout, d3_tap;
    logic       d3_dv, d3_tv;
    logic [1:0] d3_occ;

    logic [7:0] d1_dout, d1_tap;
    logic       d1_dv, d1_tv;
    logic [0:0] d1_occ;

    int total;
    int bad;

    // Single-stage reference: a plain enabled register with sync clear.
    logic [7:0] m1_d;
    logic       m1_v;

    pipe_delay_line #(.WIDTH(8), .DEPTH(4), .SEL_W(2), .CNT_W(3)) u_d4 (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .din_valid(din_valid), .din(din), .tap_sel(tap_sel),
        .dout(d4_dout), .dout_valid(d4_dv), .tap_dout(d4_tap),
        .tap_valid(d4_tv), .occupancy(d4_occ)
    );

    pipe_delay_line #(.WIDTH(8), .DEPTH(3), .SEL_W(2), .CNT_W(2)) u_d3 (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .din_valid(din_valid), .din(din), .tap_sel(tap_sel),
        .dout(d3_dout), .dout_valid(d3_dv), .tap_dout(d3_tap),
        .tap_valid(d3_tv), .occupancy(d3_occ)
    );

    pipe_delay_line #(.WIDTH(8), .DEPTH(1), .SEL_W(1), .CNT_W(1)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .din_valid(din_valid), .din(din), .tap_sel(tap_sel[0:0]),
        .dout(d1_dout), .dout_valid(d1_dv), .tap_dout(d1_tap),
        .tap_valid(d1_tv), .occupancy(d1_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one edge, then check DEPTH=4 outputs and the DEPTH=1 model.
    task automatic step(input string tag, input logic e, input logic v, input logic [7:0] d,
                        input logic [7:0] exp_dout, input logic exp_dv, input logic [2:0] exp_occ);
        en        = e;
        din_valid = v;
        din       = d;
        @(posedge clk);
        if (rst || flush) begin
            m1_d = 8'h00;
            m1_v = 1'b0;
        end else if (e) begin
            m1_d = d;
            m1_v = v;
        end
        #1;
        check({tag, ".dout"}, 32'(d4_dout), 32'(exp_dout));
        check({tag, ".dv"},   32'(d4_dv),   32'(exp_dv));
        check({tag, ".occ"},  32'(d4_occ),  32'(exp_occ));
        check({tag, ".d1"},   32'({d1_occ, d1_dv, d1_dout}), 32'({m1_v, m1_v, m1_d}));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        m1_d      = 8'h00;
        m1_v      = 1'b0;
        rst       = 1'b1;
        flush     = 1'b0;
        en        = 1'b0;
        din_valid = 1'b0;
        din       = 8'h00;
        tap_sel   = 2'd0;

        // Reset for two cycles.
        step("rst0", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0);
        step("rst1", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0);
        check("rst.tap", 32'({d4_tv, d4_tap}), 32'd0);
        rst = 1'b0;

        // Straight stream 11..88, all valid; 11 emerges after 4th edge.
        step("s1", 1'b1, 1'b1, 8'h11, 8'h00, 1'b0, 3'd1);
        step("s2", 1'b1, 1'b1, 8'h22, 8'h00, 1'b0, 3'd2);
        step("s3", 1'b1, 1'b1, 8'h33, 8'h00, 1'b0, 3'd3);
        step("s4", 1'b1, 1'b1, 8'h44, 8'h11, 1'b1, 3'd4);

        // Full pipe 44,33,22,11: combinational tap sweep, no clock edge.
        for (int i = 0; i < 4; i++) begin
            tap_sel = 2'(i);
            #1;
            check($sformatf("tap4_%0d", i), 32'({d4_tv, d4_tap}), 32'({1'b1, 8'(8'h44 - 8'(i * 8'h11))}));
            if (i < 3)
                check($sformatf("tap3_%0d", i), 32'({d3_tv, d3_tap}), 32'({1'b1, 8'(8'h44 - 8'(i * 8'h11))}));
            else
                check("tap3_oob", 32'({d3_tv, d3_tap}), 32'd0);
        end
        tap_sel = 2'd0;

        step("s5", 1'b1, 1'b1, 8'h55, 8'h22, 1'b1, 3'd4);
        step("s6", 1'b1, 1'b1, 8'h66, 8'h33, 1'b1, 3'd4);
        step("s7", 1'b1, 1'b1, 8'h77, 8'h44, 1'b1, 3'd4);
        step("s8", 1'b1, 1'b1, 8'h88, 8'h55, 1'b1, 3'd4);

        // Flush a full pipe with a valid input on the same edge.
        flush = 1'b1;
        step("fl", 1'b1, 1'b1, 8'h99, 8'h00, 1'b0, 3'd0);
        check("fl.tap", 32'({d4_tv, d4_tap}), 32'd0);
        flush = 1'b0;
        for (int i = 0; i < 4; i++)
            step($sformatf("fl_drain%0d", i), 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0);

        // Stall 3 cycles after 22 entered; din during stall is ignored.
        step("st1", 1'b1, 1'b1, 8'h11, 8'h00, 1'b0, 3'd1);
        step("st2", 1'b1, 1'b1, 8'h22, 8'h00, 1'b0, 3'd2);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("stall%0d", i), 1'b0, 1'b1, 8'hEE, 8'h00, 1'b0, 3'd2);
            check($sformatf("stall%0d.tap", i), 32'({d4_tv, d4_tap}), 32'({1'b1, 8'h22}));
        end
        step("st3", 1'b1, 1'b1, 8'h33, 8'h00, 1'b0, 3'd3);
        step("st4", 1'b1, 1'b1, 8'h44, 8'h11, 1'b1, 3'd4);
        step("st5", 1'b1, 1'b1, 8'h55, 8'h22, 1'b1, 3'd4);
        step("st6", 1'b1, 1'b0, 8'h00, 8'h33, 1'b1, 3'd3);
        step("st7", 1'b1, 1'b0, 8'h00, 8'h44, 1'b1, 3'd2);
        step("st8", 1'b1, 1'b0, 8'h00, 8'h55, 1'b1, 3'd1);
        step("st9", 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0);

        // Alternating valid: bubbles keep their data on dout.
        step("al1", 1'b1, 1'b1, 8'hA1, 8'h00, 1'b0, 3'd1);
        step("al2", 1'b1, 1'b0, 8'hB2, 8'h00, 1'b0, 3'd1);
        step("al3", 1'b1, 1'b1, 8'hC3, 8'h00, 1'b0, 3'd2);
        step("al4", 1'b1, 1'b0, 8'hD4, 8'hA1, 1'b1, 3'd2);
        step("al5", 1'b1, 1'b1, 8'hE5, 8'hB2, 1'b0, 3'd2);
        step("al6", 1'b1, 1'b0, 8'hF6, 8'hC3, 1'b1, 3'd2);
        step("al7", 1'b1, 1'b1, 8'h17, 8'hD4, 1'b0, 3'd2);

        // Reset wins over flush and en mid-stream; restart latency is DEPTH.
        rst   = 1'b1;
        flush = 1'b1;
        step("mrst", 1'b1, 1'b1, 8'h5A, 8'h00, 1'b0, 3'd0);
        check("mrst.tap", 32'({d4_tv, d4_tap}), 32'd0);
        check("mrst.d3", 32'({d3_occ, d3_dv, d3_dout}), 32'd0);
        rst   = 1'b0;
        flush = 1'b0;
        step("rs1", 1'b1, 1'b1, 8'h61, 8'h00, 1'b0, 3'd1);
        step("rs2", 1'b1, 1'b1, 8'h62, 8'h00, 1'b0, 3'd2);
        step("rs3", 1'b1, 1'b1, 8'h63, 8'h00, 1'b0, 3'd3);
        step("rs4", 1'b1, 1'b1, 8'h64, 8'h61, 1'b1, 3'd4);
        check("rs4.d3", 32'({d3_dv, d3_dout}), 32'({1'b1, 8'h62}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
